// File: rtl/e203_exu_csr_arb.sv
// e203_exu_csr_arb: two-requester (core, debug) arbiter and read-modify-write sequencer for the CSR port.
// Define E203_CSR_ARB_RR_EN for round-robin arbitration; otherwise debug has fixed priority over core.
module e203_exu_csr_arb #(
  parameter int XLEN = 32,
  parameter int IDXW = 12
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            core_req_valid,
  output logic            core_req_ready,
  input  logic [1:0]      core_req_op,
  input  logic [IDXW-1:0] core_req_idx,
  input  logic [XLEN-1:0] core_req_wdat,
  output logic            core_rsp_valid,
  input  logic            core_rsp_ready,
  output logic [XLEN-1:0] core_rsp_rdat,
  output logic            core_rsp_err,

  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic [1:0]      dbg_req_op,
  input  logic [IDXW-1:0] dbg_req_idx,
  input  logic [XLEN-1:0] dbg_req_wdat,
  output logic            dbg_rsp_valid,
  input  logic            dbg_rsp_ready,
  output logic [XLEN-1:0] dbg_rsp_rdat,
  output logic            dbg_rsp_err,

  output logic            csr_ena,
  output logic            csr_rd_en,
  output logic            csr_wr_en,
  output logic [IDXW-1:0] csr_idx,
  output logic [XLEN-1:0] wbck_csr_dat,
  input  logic [XLEN-1:0] read_csr_dat,
  input  logic            csr_access_ilgl,

  output logic            busy
);

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;
  localparam logic [1:0] OP_RO = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t            state;
  logic              src_dbg_r;
  logic [1:0]        op_r;
  logic [IDXW-1:0]   idx_r;
  logic [XLEN-1:0]   wdat_r;
  logic [XLEN-1:0]   old_r;
  logic              err_r;

  logic              prio_dbg;
  logic              grant_core;
  logic              grant_dbg;
  logic              accept;
  logic              rsp_ready_sel;
  logic              wr_need;
  logic              rsp_act;
  logic [XLEN-1:0]   rsp_dat;

  function automatic logic [XLEN-1:0] rmw_value(input logic [1:0] op,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] opnd);
    case (op)
      OP_RS:   rmw_value = old | opnd;
      OP_RC:   rmw_value = old & ~opnd;
      OP_RO:   rmw_value = old;
      default: rmw_value = opnd;
    endcase
  endfunction

`ifdef E203_CSR_ARB_RR_EN
  logic ptr_dbg_r;

  // After each grant the other requester gets priority on the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_dbg_r <= 1'b0;
    end else if (accept) begin
      ptr_dbg_r <= grant_core;
    end
  end

  assign prio_dbg = ptr_dbg_r;
`else
  assign prio_dbg = 1'b1;
`endif

  assign grant_dbg  = (state == IDLE) && dbg_req_valid  && (!core_req_valid || prio_dbg);
  assign grant_core = (state == IDLE) && core_req_valid && (!dbg_req_valid  || !prio_dbg);
  assign accept     = grant_core || grant_dbg;

  assign core_req_ready = grant_core;
  assign dbg_req_ready  = grant_dbg;

  assign rsp_ready_sel = src_dbg_r ? dbg_rsp_ready : core_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_dbg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RD;
            src_dbg_r <= grant_dbg;
          end
        end
        RD:      state <= WR;
        WR:      state <= RSP;
        RSP:     if (rsp_ready_sel) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; every output that uses them is qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= grant_dbg ? dbg_req_op   : core_req_op;
      idx_r  <= grant_dbg ? dbg_req_idx  : core_req_idx;
      wdat_r <= grant_dbg ? dbg_req_wdat : core_req_wdat;
    end
    if (state == RD) begin
      old_r <= read_csr_dat;
      err_r <= csr_access_ilgl;
    end
  end

  // Set/clear with a zero operand is a pure read and must not disturb the CSR.
  assign wr_need = !err_r && (op_r != OP_RO) &&
                   !(((op_r == OP_RS) || (op_r == OP_RC)) && (wdat_r == '0));

  assign csr_rd_en    = (state == RD);
  assign csr_wr_en    = (state == WR) && wr_need;
  assign csr_ena      = csr_rd_en || csr_wr_en;
  assign csr_idx      = csr_ena ? idx_r : '0;
  assign wbck_csr_dat = csr_wr_en ? rmw_value(op_r, old_r, wdat_r) : '0;

  assign rsp_act = (state == RSP);
  assign rsp_dat = err_r ? '0 : old_r;

  assign core_rsp_valid = rsp_act && !src_dbg_r;
  assign core_rsp_rdat  = core_rsp_valid ? rsp_dat : '0;
  assign core_rsp_err   = core_rsp_valid && err_r;

  assign dbg_rsp_valid  = rsp_act && src_dbg_r;
  assign dbg_rsp_rdat   = dbg_rsp_valid ? rsp_dat : '0;
  assign dbg_rsp_err    = dbg_rsp_valid && err_r;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_e203_exu_csr_arb.sv
// Self-checking bench for e203_exu_csr_arb: directed scenarios plus randomized accesses against a CSR-level model.
// Arbitration expectations follow E203_CSR_ARB_RR_EN when it is defined for the build.
module tb_e203_exu_csr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_valid = 1'b0, dbg_req_valid = 1'b0;
  logic        core_req_ready, dbg_req_ready;
  logic [1:0]  core_req_op = 2'b11, dbg_req_op = 2'b11;
  logic [11:0] core_req_idx = '0, dbg_req_idx = '0;
  logic [31:0] core_req_wdat = '0, dbg_req_wdat = '0;
  logic        core_rsp_valid, dbg_rsp_valid;
  logic        core_rsp_ready = 1'b0, dbg_rsp_ready = 1'b0;
  logic [31:0] core_rsp_rdat, dbg_rsp_rdat;
  logic        core_rsp_err, dbg_rsp_err;
  logic        csr_ena, csr_rd_en, csr_wr_en;
  logic [11:0] csr_idx;
  logic [31:0] wbck_csr_dat, read_csr_dat;
  logic        csr_access_ilgl;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // CSR file model: combinational read, write on the clock edge, preload port for the bench.
  logic [31:0] mem [0:4095];
  logic        ilgl_map [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_dat = '0;
  logic        pre_il = 1'b0;
  logic [31:0] shadow [0:4095];
  bit          prio_dbg_exp = 1'b0;

  assign read_csr_dat    = mem[csr_idx];
  assign csr_access_ilgl = ilgl_map[csr_idx];

  always @(posedge clk) begin
    if (csr_wr_en) mem[csr_idx] <= wbck_csr_dat;
    else if (pre_en) mem[pre_idx] <= pre_dat;
    if (pre_en) ilgl_map[pre_idx] <= pre_il;
  end

  always #5 clk = ~clk;

  e203_exu_csr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_op(core_req_op),
    .core_req_idx(core_req_idx), .core_req_wdat(core_req_wdat), .core_rsp_valid(core_rsp_valid),
    .core_rsp_ready(core_rsp_ready), .core_rsp_rdat(core_rsp_rdat), .core_rsp_err(core_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_op(dbg_req_op),
    .dbg_req_idx(dbg_req_idx), .dbg_req_wdat(dbg_req_wdat), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdat(dbg_rsp_rdat), .dbg_rsp_err(dbg_rsp_err),
    .csr_ena(csr_ena), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .wbck_csr_dat(wbck_csr_dat), .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl),
    .busy(busy)
  );

  // Observations from one access, sampled on negative edges T..T+4.
  bit          ob_timeout, ob_rd, ob_wr, ob_wr_ena, ob_rv, ob_other_rv, ob_err, ob_busy;
  int          ob_wait;
  logic [11:0] ob_rd_idx, ob_wr_idx;
  logic [31:0] ob_wb, ob_rdat;

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] old,
                                    input logic [31:0] wdat, input bit il,
                                    output bit wr, output logic [31:0] nv, output logic [31:0] rdat);
    case (op)
      2'b00: nv = wdat;
      2'b01: nv = old | wdat;
      2'b10: nv = old & ~wdat;
      default: nv = old;
    endcase
    wr   = !il && op != 2'b11 && !(op != 2'b00 && wdat == 0);
    rdat = il ? 32'h0 : old;
  endfunction

  task automatic preload(input logic [11:0] idx, input logic [31:0] dat, input bit il);
    pre_idx = idx; pre_dat = dat; pre_il = il; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    shadow[idx] = dat;
  endtask

  task automatic run_access(input bit src, input logic [1:0] op, input logic [11:0] idx,
                            input logic [31:0] wdat);
    int n;
    bit rdy;
    n = 0;
    ob_timeout = 1'b0;
    if (src) begin
      dbg_req_valid = 1'b1; dbg_req_op = op; dbg_req_idx = idx; dbg_req_wdat = wdat;
    end else begin
      core_req_valid = 1'b1; core_req_op = op; core_req_idx = idx; core_req_wdat = wdat;
    end
    #1;
    rdy = src ? dbg_req_ready : core_req_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = src ? dbg_req_ready : core_req_ready;
    end
    ob_wait = n;
    if (!rdy) begin
      ob_timeout = 1'b1;
      core_req_valid = 1'b0; dbg_req_valid = 1'b0;
      return;
    end
    prio_dbg_exp = !src;
    @(negedge clk);
    core_req_valid = 1'b0; dbg_req_valid = 1'b0;
    ob_rd = csr_rd_en && csr_ena; ob_rd_idx = csr_idx;
    @(negedge clk);
    ob_wr = csr_wr_en; ob_wr_ena = csr_ena; ob_wb = wbck_csr_dat; ob_wr_idx = csr_idx;
    @(negedge clk);
    ob_rv       = src ? dbg_rsp_valid : core_rsp_valid;
    ob_other_rv = src ? core_rsp_valid : dbg_rsp_valid;
    ob_rdat     = src ? dbg_rsp_rdat : core_rsp_rdat;
    ob_err      = src ? dbg_rsp_err : core_rsp_err;
    if (src) dbg_rsp_ready = 1'b1; else core_rsp_ready = 1'b1;
    @(negedge clk);
    ob_busy = busy;
    core_rsp_ready = 1'b0; dbg_rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({csr_ena, csr_rd_en, csr_wr_en, busy, core_req_ready, dbg_req_ready,
         core_rsp_valid, dbg_rsp_valid, core_rsp_err, dbg_rsp_err} !== 10'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {csr_ena, csr_rd_en, csr_wr_en, busy});
    end
    checks++;
    if ({csr_idx, wbck_csr_dat, core_rsp_rdat, dbg_rsp_rdat} !== '0) begin
      failures++; $display("FAIL reset_data got idx=%h wbck=%h", csr_idx, wbck_csr_dat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_core_rw;
    preload(12'h305, 32'h0, 1'b0);
    run_access(1'b0, 2'b00, 12'h305, 32'h8000_0100);
    checks++;
    if (ob_timeout) begin failures++; $display("FAIL rw_accept got=timeout exp=ready"); return; end
    checks++;
    if (!ob_rd || ob_rd_idx !== 12'h305) begin
      failures++; $display("FAIL rw_rd got rd=%b idx=%h exp rd=1 idx=305", ob_rd, ob_rd_idx);
    end
    checks++;
    if (!ob_wr || !ob_wr_ena || ob_wb !== 32'h8000_0100 || ob_wr_idx !== 12'h305) begin
      failures++; $display("FAIL rw_wr got wr=%b wbck=%h exp wr=1 wbck=80000100", ob_wr, ob_wb);
    end
    checks++;
    if (!ob_rv || ob_rdat !== 32'h0 || ob_err) begin
      failures++; $display("FAIL rw_rsp got v=%b rdat=%h err=%b exp v=1 rdat=0", ob_rv, ob_rdat, ob_err);
    end
    checks++;
    if (ob_busy !== 1'b0) begin failures++; $display("FAIL rw_idle got busy=%b exp=0", ob_busy); end
    checks++;
    if (mem[12'h305] !== 32'h8000_0100) begin
      failures++; $display("FAIL rw_file got=%h exp=80000100", mem[12'h305]);
    end
    shadow[12'h305] = 32'h8000_0100;
  endtask

  task automatic test_core_rs;
    preload(12'h300, 32'h1800, 1'b0);
    run_access(1'b0, 2'b01, 12'h300, 32'h8);
    checks++;
    if (ob_timeout || !ob_wr || ob_wb !== 32'h1808 || ob_rdat !== 32'h1800) begin
      failures++; $display("FAIL rs_set got wr=%b wbck=%h rdat=%h exp 1 1808 1800", ob_wr, ob_wb, ob_rdat);
    end
    preload(12'h300, 32'h1800, 1'b0);
    run_access(1'b0, 2'b01, 12'h300, 32'h0);
    checks++;
    if (ob_timeout || ob_wr || ob_wr_ena || ob_wb !== 32'h0 || ob_rdat !== 32'h1800) begin
      failures++; $display("FAIL rs_zero got wr=%b wbck=%h rdat=%h exp 0 0 1800", ob_wr, ob_wb, ob_rdat);
    end
  endtask

  task automatic test_dbg_rc_ro;
    preload(12'h7b0, 32'hFF, 1'b0);
    run_access(1'b1, 2'b10, 12'h7b0, 32'hF);
    checks++;
    if (ob_timeout || !ob_wr || ob_wb !== 32'hF0 || ob_rdat !== 32'hFF || ob_other_rv) begin
      failures++; $display("FAIL dbg_rc got wr=%b wbck=%h rdat=%h core_v=%b exp 1 f0 ff 0",
                           ob_wr, ob_wb, ob_rdat, ob_other_rv);
    end
    run_access(1'b1, 2'b11, 12'h7b0, 32'hFFFF_FFFF);
    checks++;
    if (ob_timeout || ob_wr || ob_rdat !== 32'hF0 || !ob_rv) begin
      failures++; $display("FAIL dbg_ro got wr=%b rdat=%h v=%b exp 0 f0 1", ob_wr, ob_rdat, ob_rv);
    end
    shadow[12'h7b0] = 32'hF0;
  endtask

  task automatic test_illegal;
    preload(12'h7c0, 32'hDEAD_BEEF, 1'b1);
    run_access(1'b0, 2'b00, 12'h7c0, 32'h1234_5678);
    checks++;
    if (ob_timeout || ob_wr || ob_wr_ena || !ob_err || ob_rdat !== 32'h0 || !ob_rv) begin
      failures++; $display("FAIL illegal got wr=%b err=%b rdat=%h exp 0 1 0", ob_wr, ob_err, ob_rdat);
    end
  endtask

  task automatic test_back_to_back;
    preload(12'h010, 32'h10, 1'b0);
    run_access(1'b0, 2'b11, 12'h010, 32'h0);
    run_access(1'b0, 2'b01, 12'h010, 32'h1);
    checks++;
    if (ob_timeout || ob_wait != 0) begin
      failures++; $display("FAIL b2b_wait got=%0d exp=0", ob_wait);
    end
    checks++;
    if (ob_wb !== 32'h11 || ob_rdat !== 32'h10) begin
      failures++; $display("FAIL b2b_data got wbck=%h rdat=%h exp 11 10", ob_wb, ob_rdat);
    end
    shadow[12'h010] = 32'h11;
  endtask

  task automatic test_arbitration;
    int got[$];
    int n;
    bit exp_dbg;
    core_req_valid = 1'b1; core_req_op = 2'b11; core_req_idx = 12'h010; core_req_wdat = '0;
    dbg_req_valid  = 1'b1; dbg_req_op  = 2'b11; dbg_req_idx  = 12'h010; dbg_req_wdat  = '0;
    core_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;
    n = 0;
    while (got.size() < 3 && n < 60) begin
      #1;
      if (core_req_ready && dbg_req_ready) begin
        checks++; failures++; $display("FAIL arb_both_ready got=11 exp=one-hot");
      end
      if (core_req_ready) got.push_back(0);
      else if (dbg_req_ready) got.push_back(1);
      @(negedge clk);
      n++;
    end
    core_req_valid = 1'b0; dbg_req_valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    core_rsp_ready = 1'b0; dbg_rsp_ready = 1'b0;
    checks++;
    if (got.size() != 3 || busy) begin
      failures++; $display("FAIL arb_grants got=%0d exp=3", got.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
`ifdef E203_CSR_ARB_RR_EN
      exp_dbg = prio_dbg_exp;
`else
      exp_dbg = 1'b1;
`endif
      prio_dbg_exp = !exp_dbg;
      checks++;
      if (got[i] != int'(exp_dbg)) begin
        failures++; $display("FAIL arb_order[%0d] got=%0d exp=%0d", i, got[i], exp_dbg);
      end
    end
  endtask

  task automatic test_rsp_hold;
    int n;
    preload(12'h020, 32'h1234, 1'b0);
    core_req_valid = 1'b1; core_req_op = 2'b00; core_req_idx = 12'h020; core_req_wdat = 32'h55;
    n = 0;
    #1;
    while (!core_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!core_req_ready) begin
      core_req_valid = 1'b0; failures++; $display("FAIL hold_accept got=timeout exp=ready"); return;
    end
    prio_dbg_exp = 1'b1;
    @(negedge clk); core_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dbg_req_valid = 1'b1; dbg_req_op = 2'b11; dbg_req_idx = 12'h020; dbg_req_wdat = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (core_rsp_valid !== 1'b1 || core_rsp_rdat !== 32'h1234 || core_rsp_err !== 1'b0 ||
          dbg_req_ready !== 1'b0 || dbg_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL hold_cycle%0d got v=%b rdat=%h dbg_rdy=%b exp 1 1234 0",
                             i, core_rsp_valid, core_rsp_rdat, dbg_req_ready);
      end
      @(negedge clk);
    end
    core_rsp_ready = 1'b1;
    @(negedge clk);
    core_rsp_ready = 1'b0;
    #1;
    checks++;
    if (dbg_req_ready !== 1'b1 || core_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release got dbg_rdy=%b v=%b exp 1 0", dbg_req_ready, core_rsp_valid);
    end
    dbg_req_valid = 1'b0;
    shadow[12'h020] = 32'h55;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    preload(12'h030, 32'hAAAA, 1'b0);
    core_req_valid = 1'b1; core_req_op = 2'b00; core_req_idx = 12'h030; core_req_wdat = 32'h5555;
    n = 0;
    #1;
    while (!core_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!core_req_ready) begin
      core_req_valid = 1'b0; failures++; $display("FAIL rstmid_accept got=timeout exp=ready"); return;
    end
    @(negedge clk); core_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (csr_wr_en !== 1'b1) begin failures++; $display("FAIL rstmid_wr got=%b exp=1", csr_wr_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({csr_ena, csr_rd_en, csr_wr_en, busy, core_rsp_valid, dbg_rsp_valid, core_rsp_err} !== 7'b0 ||
        {csr_idx, wbck_csr_dat, core_rsp_rdat} !== '0) begin
      failures++; $display("FAIL rstmid_outputs got ena=%b wr=%b busy=%b wbck=%h exp all 0",
                           csr_ena, csr_wr_en, busy, wbck_csr_dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prio_dbg_exp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || core_rsp_valid !== 1'b0 || csr_ena !== 1'b0) begin
        failures++; $display("FAIL rstmid_idle got busy=%b v=%b ena=%b exp 0", busy, core_rsp_valid, csr_ena);
      end
    end
    checks++;
    if (mem[12'h030] !== 32'hAAAA) begin
      failures++; $display("FAIL rstmid_file got=%h exp=aaaa", mem[12'h030]);
    end
  endtask

  task automatic test_random;
    logic [11:0] idx;
    logic [31:0] wdat, nv, rdat;
    logic [1:0]  op;
    bit          src, il, wr;
    bit          il_tab [0:7];
    for (int i = 0; i < 8; i++) begin
      il_tab[i] = ($urandom_range(0, 7) == 0);
      preload(12'h100 + 12'(i), $urandom, il_tab[i]);
    end
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel  = $urandom_range(0, 7);
      idx  = 12'h100 + 12'(sel);
      il   = il_tab[sel];
      src  = 1'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 3));
      wdat = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      ref_model(op, shadow[idx], wdat, il, wr, nv, rdat);
      run_access(src, op, idx, wdat);
      checks++;
      if (ob_timeout || !ob_rd || ob_rd_idx !== idx) begin
        failures++; $display("FAIL rand%0d_rd got rd=%b idx=%h exp 1 %h", k, ob_rd, ob_rd_idx, idx);
      end
      checks++;
      if (ob_wr !== wr || ob_wb !== (wr ? nv : 32'h0) || ob_wr_idx !== (wr ? idx : 12'h0)) begin
        failures++; $display("FAIL rand%0d_wr got wr=%b wbck=%h exp wr=%b wbck=%h", k, ob_wr, ob_wb, wr, nv);
      end
      checks++;
      if (!ob_rv || ob_other_rv || ob_rdat !== rdat || ob_err !== il) begin
        failures++; $display("FAIL rand%0d_rsp got rdat=%h err=%b exp rdat=%h err=%b", k, ob_rdat, ob_err, rdat, il);
      end
      if (wr) shadow[idx] = nv;
    end
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_core_rs();
    test_dbg_rc_ro();
    test_illegal();
    test_back_to_back();
    test_arbitration();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
